fix_field_stream: RTL and testbench

Parametrised streaming FIX field extractor. It replaces the fixed 32-bit-tag / 256-bit-value parser front end with a byte-stream block that has ready/valid backpressure on both sides. It converts ASCII tags to binary, packs variable-length values and buffers completed fields in an output FIFO. It also verifies the FIX trailer checksum (tag 10) in-line. It sits between the byte source and the tag CAM / value RAM writers.

---
 rtl/fix_field_stream.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_fix_field_stream.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fix_field_stream.sv
// -----------------------------------------------------------------------------
// fix_field_stream
//
// Streaming FIX field extractor. Consumes a byte stream with ready/valid
// backpressure, converts the ASCII tag of each "tag=value<SOH>" field to
// binary, packs the value bytes little-end-first into a wide word and pushes
// completed fields into a small output FIFO. The trailer checksum (tag 10)
// can be verified in-line.
//
// Optional feature macro: FIX_CHECKSUM_EN
//   defined   : running byte sum, field-boundary snapshot and tag-10 compare
//   undefined : checksum logic absent, checksum_valid_o/checksum_ok_o tied 0
//
// Parameters
//   VALUE_BYTES : maximum stored value length in bytes
//   TAG_WIDTH   : binary tag width (at most 9 decimal digits accepted)
//   FIFO_DEPTH  : output FIFO entries (power of two, >= 2)
//
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-low reset
//   data_i            : input byte
//   data_valid_i      : input byte valid
//   data_ready_o      : input byte accepted when valid && ready (FIFO not full)
//   new_message_i     : accepted byte is the first byte of a message
//   field_valid_o     : FIFO head valid
//   field_ready_i     : pop FIFO head when valid && ready
//   tag_o             : head field binary tag
//   value_o           : head field value, first byte in [7:0], unused bytes 0
//   value_len_o       : stored value byte count
//   value_trunc_o     : value was longer than VALUE_BYTES
//   field_last_o      : head field is tag 10
//   checksum_valid_o  : one-cycle pulse, trailer checked
//   checksum_ok_o     : trailer checksum matched (qualified by valid)
//   error_o           : one-cycle code 0 none, 1 bad/empty tag,
//                       2 tag longer than 9 digits, 3 value truncated
//   dbg_state_o       : current parser state (0 TAG, 1 VALUE, 2 SKIP)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and data is held while valid is
// high and ready is low.
// -----------------------------------------------------------------------------
module fix_field_stream #(
   parameter int VALUE_BYTES = 32,
   parameter int TAG_WIDTH   = 32,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [7:0]                       data_i,
   input  logic                             data_valid_i,
   output logic                             data_ready_o,
   input  logic                             new_message_i,
   output logic                             field_valid_o,
   input  logic                             field_ready_i,
   output logic [TAG_WIDTH-1:0]             tag_o,
   output logic [8*VALUE_BYTES-1:0]         value_o,
   output logic [$clog2(VALUE_BYTES+1)-1:0] value_len_o,
   output logic                             value_trunc_o,
   output logic                             field_last_o,
   output logic                             checksum_valid_o,
   output logic                             checksum_ok_o,
   output logic [1:0]                       error_o,
   output logic [1:0]                       dbg_state_o
);

   localparam int LEN_W = $clog2(VALUE_BYTES + 1);
   localparam int VAL_W = 8 * VALUE_BYTES;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_TAG   = 2'd0,
      ST_VALUE = 2'd1,
      ST_SKIP  = 2'd2
   } state_t;

   // Parser registers
   state_t               r_state;
   logic [TAG_WIDTH-1:0] r_tag;
   logic [3:0]           r_cnt;
   logic [VAL_W-1:0]     r_val;
   logic [LEN_W-1:0]     r_len;
   logic                 r_trunc;
   logic [1:0]           r_err;

   // FIFO registers
   logic [TAG_WIDTH-1:0] r_mem_tag   [FIFO_DEPTH];
   logic [VAL_W-1:0]     r_mem_val   [FIFO_DEPTH];
   logic [LEN_W-1:0]     r_mem_len   [FIFO_DEPTH];
   logic                 r_mem_trunc [FIFO_DEPTH];
   logic                 r_mem_last  [FIFO_DEPTH];
   logic [PTR_W-1:0]     r_wr_ptr;
   logic [PTR_W-1:0]     r_rd_ptr;
   logic [CNT_W-1:0]     r_count;

   // Next-state / datapath wires
   state_t               w_state_nxt;
   state_t               w_cur_state;
   logic [TAG_WIDTH-1:0] w_cur_tag;
   logic [3:0]           w_cur_cnt;
   logic [TAG_WIDTH-1:0] w_tag_nxt;
   logic [3:0]           w_cnt_nxt;
   logic [VAL_W-1:0]     w_val_nxt;
   logic [LEN_W-1:0]     w_len_nxt;
   logic                 w_trunc_nxt;
   logic [1:0]           w_err_nxt;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_accept;
   logic                 w_is_soh;
   logic                 w_is_eq;
   logic                 w_is_digit;
   logic [7:0]           w_digit;
   logic                 w_push_last;

   assign data_ready_o  = (r_count != CNT_W'(FIFO_DEPTH));
   assign w_accept      = data_valid_i && data_ready_o;
   assign w_pop         = (r_count != '0) && field_ready_i;
   assign w_is_soh      = (data_i == 8'h01);
   assign w_is_eq       = (data_i == 8'h3d);
   assign w_is_digit    = (data_i >= 8'h30) && (data_i <= 8'h39);
   assign w_digit       = data_i - 8'h30;
   assign w_push_last   = (r_tag == TAG_WIDTH'(10));

   assign field_valid_o = (r_count != '0);
   assign tag_o         = r_mem_tag[r_rd_ptr];
   assign value_o       = r_mem_val[r_rd_ptr];
   assign value_len_o   = r_mem_len[r_rd_ptr];
   assign value_trunc_o = r_mem_trunc[r_rd_ptr];
   assign field_last_o  = r_mem_last[r_rd_ptr];
   assign error_o       = r_err;
   assign dbg_state_o   = r_state;

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_TAG;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state and parser datapath
   always_comb begin
      w_cur_state = r_state;
      w_cur_tag   = r_tag;
      w_cur_cnt   = r_cnt;
      w_state_nxt = r_state;
      w_tag_nxt   = r_tag;
      w_cnt_nxt   = r_cnt;
      w_val_nxt   = r_val;
      w_len_nxt   = r_len;
      w_trunc_nxt = r_trunc;
      w_err_nxt   = 2'd0;
      w_push      = 1'b0;

      if (w_accept) begin
         // A message start overrides any partial field before the byte is parsed.
         if (new_message_i) begin
            w_cur_state = ST_TAG;
            w_cur_tag   = '0;
            w_cur_cnt   = '0;
         end
         w_state_nxt = w_cur_state;
         w_tag_nxt   = w_cur_tag;
         w_cnt_nxt   = w_cur_cnt;

         case (w_cur_state)
            ST_TAG: begin
               if (w_is_digit) begin
                  if (w_cur_cnt == 4'd9) begin
                     w_err_nxt   = 2'd2;
                     w_state_nxt = ST_SKIP;
                  end else begin
                     w_tag_nxt = w_cur_tag * TAG_WIDTH'(10) + TAG_WIDTH'(w_digit);
                     w_cnt_nxt = w_cur_cnt + 4'd1;
                  end
               end else if (w_is_eq && (w_cur_cnt != 4'd0)) begin
                  w_state_nxt = ST_VALUE;
                  w_val_nxt   = '0;
                  w_len_nxt   = '0;
                  w_trunc_nxt = 1'b0;
               end else if (w_is_soh) begin
                  // A lone SOH between fields is harmless; one after digits is not.
                  if (w_cur_cnt != 4'd0) begin
                     w_err_nxt = 2'd1;
                     w_tag_nxt = '0;
                     w_cnt_nxt = '0;
                  end
               end else begin
                  w_err_nxt   = 2'd1;
                  w_state_nxt = ST_SKIP;
               end
            end
            ST_VALUE: begin
               if (w_is_soh) begin
                  w_push      = 1'b1;
                  w_state_nxt = ST_TAG;
                  w_tag_nxt   = '0;
                  w_cnt_nxt   = '0;
                  if (r_trunc) w_err_nxt = 2'd3;
               end else if (r_len < LEN_W'(VALUE_BYTES)) begin
                  for (int i = 0; i < VALUE_BYTES; i++) begin
                     if (r_len == LEN_W'(i)) w_val_nxt[8*i +: 8] = data_i;
                  end
                  w_len_nxt = r_len + LEN_W'(1);
               end else begin
                  w_trunc_nxt = 1'b1;
               end
            end
            ST_SKIP: begin
               if (w_is_soh) begin
                  w_state_nxt = ST_TAG;
                  w_tag_nxt   = '0;
                  w_cnt_nxt   = '0;
               end
            end
            default: begin
               w_state_nxt = ST_TAG;
               w_tag_nxt   = '0;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Parser datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tag   <= '0;
         r_cnt   <= '0;
         r_val   <= '0;
         r_len   <= '0;
         r_trunc <= 1'b0;
         r_err   <= 2'd0;
      end else begin
         r_tag   <= w_tag_nxt;
         r_cnt   <= w_cnt_nxt;
         r_val   <= w_val_nxt;
         r_len   <= w_len_nxt;
         r_trunc <= w_trunc_nxt;
         r_err   <= w_err_nxt;
      end
   end

   // Output FIFO. A push only happens while not full since input is stalled
   // when full, so simultaneous push/pop never overflows.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem_tag[i]   <= '0;
            r_mem_val[i]   <= '0;
            r_mem_len[i]   <= '0;
            r_mem_trunc[i] <= 1'b0;
            r_mem_last[i]  <= 1'b0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem_tag[r_wr_ptr]   <= r_tag;
            r_mem_val[r_wr_ptr]   <= r_val;
            r_mem_len[r_wr_ptr]   <= r_len;
            r_mem_trunc[r_wr_ptr] <= r_trunc;
            r_mem_last[r_wr_ptr]  <= w_push_last;
            r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

`ifdef FIX_CHECKSUM_EN
   logic [7:0] r_sum;
   logic [7:0] r_snap;
   logic       r_ck_valid;
   logic       r_ck_ok;
   logic [7:0] w_sum_add;
   logic [7:0] w_hund;
   logic [7:0] w_tens;
   logic [7:0] w_units;
   logic       w_ck_match;

   // Sum restarts with the message; the snapshot taken at each SOH is the sum
   // up to and including it, so at the tag-10 push it excludes the trailer.
   assign w_sum_add  = (new_message_i ? 8'd0 : r_sum) + data_i;
   assign w_hund     = 8'h30 + (r_snap / 8'd100);
   assign w_tens     = 8'h30 + ((r_snap / 8'd10) % 8'd10);
   assign w_units    = 8'h30 + (r_snap % 8'd10);
   assign w_ck_match = (r_len == LEN_W'(3)) && (r_val[7:0] == w_hund) &&
                       (r_val[15:8] == w_tens) && (r_val[23:16] == w_units);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sum      <= 8'd0;
         r_snap     <= 8'd0;
         r_ck_valid <= 1'b0;
         r_ck_ok    <= 1'b0;
      end else begin
         r_ck_valid <= w_push && w_push_last;
         r_ck_ok    <= w_push && w_push_last && w_ck_match;
         if (w_accept) begin
            if (w_push && w_push_last) begin
               r_sum <= 8'd0;
            end else begin
               r_sum <= w_sum_add;
            end
            if (w_is_soh) begin
               r_snap <= w_sum_add;
            end
         end
      end
   end

   assign checksum_valid_o = r_ck_valid;
   assign checksum_ok_o    = r_ck_ok;
`else
   assign checksum_valid_o = 1'b0;
   assign checksum_ok_o    = 1'b0;
`endif

endmodule

// File: tb/tb_fix_field_stream.sv
// -----------------------------------------------------------------------------
// tb_fix_field_stream
//
// Directed scoreboard bench for fix_field_stream. Stimulus tasks push the
// hand-derived expected fields, error codes and checksum verdicts into queues;
// monitors on the falling edge pop and compare whenever the DUT presents a
// field pop, an error pulse or a checksum pulse.
// -----------------------------------------------------------------------------
module tb_fix_field_stream;

   localparam int VB = 32;
   localparam int TW = 32;
   localparam int FD = 4;
   localparam int VW = 8 * VB;
   localparam int LW = $clog2(VB + 1);

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    data_i;
   logic          data_valid_i;
   logic          data_ready_o;
   logic          new_message_i;
   logic          field_valid_o;
   logic          field_ready_i;
   logic [TW-1:0] tag_o;
   logic [VW-1:0] value_o;
   logic [LW-1:0] value_len_o;
   logic          value_trunc_o;
   logic          field_last_o;
   logic          checksum_valid_o;
   logic          checksum_ok_o;
   logic [1:0]    error_o;
   logic [1:0]    dbg_state_o;

   always #5 clk = ~clk;

   fix_field_stream #(
      .VALUE_BYTES (VB),
      .TAG_WIDTH   (TW),
      .FIFO_DEPTH  (FD)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .data_i           (data_i),
      .data_valid_i     (data_valid_i),
      .data_ready_o     (data_ready_o),
      .new_message_i    (new_message_i),
      .field_valid_o    (field_valid_o),
      .field_ready_i    (field_ready_i),
      .tag_o            (tag_o),
      .value_o          (value_o),
      .value_len_o      (value_len_o),
      .value_trunc_o    (value_trunc_o),
      .field_last_o     (field_last_o),
      .checksum_valid_o (checksum_valid_o),
      .checksum_ok_o    (checksum_ok_o),
      .error_o          (error_o),
      .dbg_state_o      (dbg_state_o)
   );

   // ---------------- scoreboard state ----------------
   int            n_checks  = 0;
   int            n_errors  = 0;
   int            bytes_acc = 0;
   int            ck_pulses = 0;
   logic [TW-1:0] exp_tag_q[$];
   logic [VW-1:0] exp_val_q[$];
   logic [LW-1:0] exp_len_q[$];
   logic          exp_trunc_q[$];
   logic          exp_last_q[$];
   logic [1:0]    exp_err_q[$];
   logic          exp_ck_q[$];

   task automatic check(input string name, input logic [VW-1:0] act,
                        input logic [VW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [VW-1:0] pack_str(input string s);
      logic [VW-1:0] v;
      v = '0;
      for (int i = 0; i < s.len() && i < VB; i++) v[8*i +: 8] = s[i];
      return v;
   endfunction

   task automatic expect_field(input int tag, input string v, input int len,
                               input logic trunc, input logic last);
      exp_tag_q.push_back(TW'(tag));
      exp_val_q.push_back(pack_str(v));
      exp_len_q.push_back(LW'(len));
      exp_trunc_q.push_back(trunc);
      exp_last_q.push_back(last);
   endtask

   // ---------------- driver tasks ----------------
   // Called at posedge+1; returns at posedge+1 after the byte is accepted.
   task automatic send_byte(input logic [7:0] b, input logic nm);
      int guard;
      guard         = 0;
      data_i        = b;
      new_message_i = nm;
      data_valid_i  = 1'b1;
      @(negedge clk);
      while (!data_ready_o && guard < 2000) begin
         guard++;
         @(negedge clk);
      end
      if (!data_ready_o) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_timeout: data_ready_o=%0b required 1", data_ready_o);
         data_valid_i = 1'b0;
      end else begin
         @(posedge clk);
         bytes_acc++;
         #1;
      end
      new_message_i = 1'b0;
   endtask

   // '|' stands for SOH (0x01); nm flags the first byte as a message start.
   task automatic send_str(input string s, input logic nm);
      for (int i = 0; i < s.len(); i++) begin
         logic [7:0] b;
         b = s[i];
         if (b == "|") b = 8'h01;
         send_byte(b, nm && (i == 0));
      end
      data_valid_i = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 500 && exp_tag_q.size() != 0; i++) @(negedge clk);
   endtask

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (field_valid_o && field_ready_i) begin
         if (exp_tag_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL field_unexpected: got tag %0d, required no field", tag_o);
         end else begin
            check("field_tag",   VW'(tag_o),         VW'(exp_tag_q.pop_front()));
            check("field_value", value_o,            exp_val_q.pop_front());
            check("field_len",   VW'(value_len_o),   VW'(exp_len_q.pop_front()));
            check("field_trunc", VW'(value_trunc_o), VW'(exp_trunc_q.pop_front()));
            check("field_last",  VW'(field_last_o),  VW'(exp_last_q.pop_front()));
         end
      end
      if (error_o != 2'd0) begin
         if (exp_err_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL error_unexpected: got error %0d, required 0", error_o);
         end else begin
            check("error_code", VW'(error_o), VW'(exp_err_q.pop_front()));
         end
      end
      if (checksum_valid_o) begin
         ck_pulses++;
         if (exp_ck_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL checksum_unexpected: got pulse ok=%0b, required none", checksum_ok_o);
         end else begin
            check("checksum_ok", VW'(checksum_ok_o), VW'(exp_ck_q.pop_front()));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      string long_v;
      rst           = 1'b0;
      data_i        = 8'h00;
      data_valid_i  = 1'b0;
      new_message_i = 1'b0;
      field_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_field_valid", VW'(field_valid_o),    VW'(0));
      check("rst_tag",         VW'(tag_o),            VW'(0));
      check("rst_value",       value_o,               VW'(0));
      check("rst_len",         VW'(value_len_o),      VW'(0));
      check("rst_trunc",       VW'(value_trunc_o),    VW'(0));
      check("rst_last",        VW'(field_last_o),     VW'(0));
      check("rst_ck_valid",    VW'(checksum_valid_o), VW'(0));
      check("rst_error",       VW'(error_o),          VW'(0));
      check("rst_ready",       VW'(data_ready_o),     VW'(1));
      check("rst_state",       VW'(dbg_state_o),      VW'(0));
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Message with correct trailer: byte sum of the body is 929 mod 256 = 161
      expect_field(8,  "FIX.4.2", 7, 1'b0, 1'b0);
      expect_field(9,  "5",       1, 1'b0, 1'b0);
      expect_field(35, "0",       1, 1'b0, 1'b0);
      expect_field(10, "161",     3, 1'b0, 1'b1);
`ifdef FIX_CHECKSUM_EN
      exp_ck_q.push_back(1'b1);
`endif
      send_str("8=FIX.4.2|9=5|35=0|10=161|", 1'b1);

      // Same message with a wrong trailer
      expect_field(8,  "FIX.4.2", 7, 1'b0, 1'b0);
      expect_field(9,  "5",       1, 1'b0, 1'b0);
      expect_field(35, "0",       1, 1'b0, 1'b0);
      expect_field(10, "160",     3, 1'b0, 1'b1);
`ifdef FIX_CHECKSUM_EN
      exp_ck_q.push_back(1'b0);
`endif
      send_str("8=FIX.4.2|9=5|35=0|10=160|", 1'b1);

      // Value of VB+5 bytes: first VB kept, trunc flagged, error 3
      long_v = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijk";
      expect_field(58, long_v.substr(0, VB - 1), VB, 1'b1, 1'b0);
      exp_err_q.push_back(2'd3);
      send_str({"58=", long_v, "|"}, 1'b1);

      // Bad tags: empty, non-digit, ten digits; then a good field
      exp_err_q.push_back(2'd1);
      exp_err_q.push_back(2'd1);
      exp_err_q.push_back(2'd2);
      expect_field(35, "0", 1, 1'b0, 1'b0);
      send_str("=5|3A=1|1234567890=1|35=0|", 1'b1);

      // Backpressure: FD+2 fields with the sink stalled
      wait_drain();
      @(posedge clk);
      #1;
      field_ready_i = 1'b0;
      bytes_acc     = 0;
      expect_field(1, "a", 1, 1'b0, 1'b0);
      expect_field(2, "b", 1, 1'b0, 1'b0);
      expect_field(3, "c", 1, 1'b0, 1'b0);
      expect_field(4, "d", 1, 1'b0, 1'b0);
      expect_field(5, "e", 1, 1'b0, 1'b0);
      expect_field(6, "f", 1, 1'b0, 1'b0);
      fork
         send_str("1=a|2=b|3=c|4=d|5=e|6=f|", 1'b1);
      join_none
      repeat (40) @(negedge clk);
      check("bp_ready_low",       VW'(data_ready_o),  VW'(0));
      check("bp_bytes_accepted",  VW'(bytes_acc),     VW'(4 * FD));
      check("bp_head_valid",      VW'(field_valid_o), VW'(1));
      check("bp_head_tag",        VW'(tag_o),         VW'(1));
      check("bp_head_value",      value_o,            pack_str("a"));
      @(posedge clk);
      #1;
      field_ready_i = 1'b1;
      wait fork;

      // new_message_i mid-value discards the partial field
      expect_field(8, "FIX", 3, 1'b0, 1'b0);
      send_str("8=FI", 1'b1);
      send_str("8=FIX|", 1'b1);

      // Asynchronous reset with a field queued and a partial field in flight
      wait_drain();
      @(posedge clk);
      #1;
      field_ready_i = 1'b0;
      send_str("9=5|7=ab", 1'b1);
      @(negedge clk);
      check("pre_reset_valid", VW'(field_valid_o), VW'(1));
      #2;
      rst = 1'b0;
      #1;
      check("async_reset_valid", VW'(field_valid_o), VW'(0));
      check("async_reset_ready", VW'(data_ready_o),  VW'(1));
      @(posedge clk);
      #3;
      rst = 1'b1;
      @(posedge clk);
      #1;
      field_ready_i = 1'b1;
      expect_field(35, "0", 1, 1'b0, 1'b0);
      send_str("35=0|", 1'b0);

      // Final report
      wait_drain();
      repeat (5) @(negedge clk);
      check("fields_outstanding", VW'(exp_tag_q.size()), VW'(0));
      check("errors_outstanding", VW'(exp_err_q.size()), VW'(0));
      check("ck_outstanding",     VW'(exp_ck_q.size()),  VW'(0));
`ifdef FIX_CHECKSUM_EN
      check("ck_pulse_count", VW'(ck_pulses), VW'(2));
`else
      check("ck_pulse_count", VW'(ck_pulses), VW'(0));
`endif
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
